// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture: measures high time and period of an asynchronous PWM line.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pwm_capture #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             E,
    input  logic             In,
    output logic [CNT_W-1:0] Duty,
    output logic [CNT_W-1:0] Period,
    output logic             Valid,
    output logic             Timeout,
    output logic             Locked,
    output logic             Level
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_hcnt;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_duty;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_timeout;
    logic                   r_locked;
    logic [CNT_W-1:0]       w_hcnt_nx;
    logic [CNT_W-1:0]       w_pcnt_nx;
    logic [CNT_W-1:0]       w_duty_nx;
    logic [CNT_W-1:0]       w_period_nx;
    logic                   w_valid_nx;
    logic                   w_timeout_nx;
    logic                   w_locked_nx;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_pcnt_max;
    logic [CNT_W-1:0]       w_pcnt_inc;
    logic [CNT_W-1:0]       w_hcnt_inc;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_prev;
    assign w_fall     = ~w_s & r_prev;
    assign w_pcnt_max = (r_pcnt == c_CNT_MAX);
    assign w_pcnt_inc = w_pcnt_max ? r_pcnt : r_pcnt + c_CNT_ONE;
    assign w_hcnt_inc = (r_hcnt == c_CNT_MAX) ? r_hcnt : r_hcnt + c_CNT_ONE;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], In};
            r_prev <= w_s;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_hcnt    <= '0;
            r_pcnt    <= '0;
            r_duty    <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_hcnt    <= w_hcnt_nx;
            r_pcnt    <= w_pcnt_nx;
            r_duty    <= w_duty_nx;
            r_period  <= w_period_nx;
            r_valid   <= w_valid_nx;
            r_timeout <= w_timeout_nx;
            r_locked  <= w_locked_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_hcnt_nx    = r_hcnt;
        w_pcnt_nx    = r_pcnt;
        w_duty_nx    = r_duty;
        w_period_nx  = r_period;
        w_valid_nx   = 1'b0;
        w_timeout_nx = 1'b0;
        w_locked_nx  = r_locked;
        if (!E) begin
            w_state_nx  = S_IDLE;
            w_hcnt_nx   = '0;
            w_pcnt_nx   = '0;
            w_locked_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_hcnt_nx  = '0;
                    w_pcnt_nx  = '0;
                    w_state_nx = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_hcnt_nx  = c_CNT_ONE;
                        w_pcnt_nx  = c_CNT_ONE;
                        w_state_nx = S_HIGH;
                    end
                end
                S_HIGH: begin
                    // A rise cannot occur here, so saturation alone means timeout
                    if (w_pcnt_max) begin
                        w_timeout_nx = 1'b1;
                        w_locked_nx  = 1'b0;
                        w_state_nx   = S_ARM;
                    end else begin
                        w_pcnt_nx = w_pcnt_inc;
                        if (w_fall) begin
                            w_state_nx = S_LOW;
                        end else begin
                            w_hcnt_nx = w_hcnt_inc;
                        end
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_duty_nx   = r_hcnt;
                        w_period_nx = r_pcnt;
                        w_valid_nx  = 1'b1;
                        w_locked_nx = 1'b1;
                        w_hcnt_nx   = c_CNT_ONE;
                        w_pcnt_nx   = c_CNT_ONE;
                        w_state_nx  = S_HIGH;
                    end else if (w_pcnt_max) begin
                        w_timeout_nx = 1'b1;
                        w_locked_nx  = 1'b0;
                        w_state_nx   = S_ARM;
                    end else begin
                        w_pcnt_nx = w_pcnt_inc;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign Duty    = r_duty;
    assign Period  = r_period;
    assign Valid   = r_valid;
    assign Timeout = r_timeout;
    assign Locked  = r_locked;
    assign Level   = w_s;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the PWM generator. It samples an asynchronous PWM line, synchronizes it, and detects its edges. It measures the high time and the full period in Clk cycles and publishes each completed period as a duty/period pair with a one-cycle valid strobe. It sits on the input side of the design, for loopback checking of the PWM output and for decoding externally generated PWM.

Parameters:
CNT_W, 8, width of the high-time and period counters/outputs; maximum measurable value is 2^CNT_W-1.
SYNC_STAGES, 2, number of synchronizer flops on In (minimum 2).

Ports:
Clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
E  input  1  capture enable; 0 forces IDLE
In  input  1  asynchronous PWM line
Duty  output  CNT_W  high time of last complete period, in cycles
Period  output  CNT_W  length of last complete period, in cycles
Valid  output  1  one-cycle pulse when Duty/Period update
Timeout  output  1  one-cycle pulse when no rising edge arrives within 2^CNT_W-1 cycles
Locked  output  1  1 after the first Valid; cleared on Timeout, E=0 or reset
Level  output  1  synchronized level of In

Behaviour:
- Reset (synchronous, active-high): synchronizer flops, edge flop, counters, Duty, Period, Valid, Timeout, Locked and Level all clear to 0. State goes to IDLE. Reset has priority over E.
- Synchronizer: In passes through SYNC_STAGES flops to give s; Level = s. A prev flop holds s delayed by one cycle.
- Edge detect: rise = s & ~prev; fall = ~s & prev. A pin change is seen as rise or fall SYNC_STAGES cycles later.
- Counters: hcnt and pcnt, both CNT_W bits, both saturating, never wrapping.
- FSM states: IDLE, ARM, HIGH, LOW.
- IDLE:
  - Counters are held at 0.
  - If E=1, go to ARM the next cycle.
- ARM: discards any partial first period.
  - On rise: hcnt<=1, pcnt<=1, go to HIGH.
  - Fall is ignored.
  - No timeout in ARM.
- HIGH, each cycle:
  - pcnt++.
  - On fall: hcnt holds, go to LOW.
  - Otherwise: hcnt++.
- LOW:
  - On rise: Duty<=hcnt, Period<=pcnt, Valid<=1, Locked<=1, then hcnt<=1, pcnt<=1, go to HIGH.
  - Otherwise: pcnt++.
- Resulting values: a rise at cycle t0, a fall at t0+H and the next rise at t0+P give Duty=H and Period=P. Valid asserts in the cycle after the second rise.
- Timeout: in HIGH or LOW, if pcnt==2^CNT_W-1 and there is no rise this cycle:
  - Timeout<=1 for one cycle, Locked<=0, go to ARM.
  - Duty and Period hold their last values; Valid is not asserted.
- Simultaneous rise with pcnt==max in LOW: publishing wins. Valid asserts with Period=2^CNT_W-1; no Timeout.
- Stuck-high (100% duty) and stuck-low (0% duty) inputs both end in Timeout. Software reads Level to tell which.
- E=0 in any state: go to IDLE next cycle and clear counters. Valid, Timeout and Locked are 0 from the next cycle. Duty and Period hold.
- Re-enabling restarts at ARM, so the first partial period is always discarded.
- Valid and Timeout are mutually exclusive and are never asserted in consecutive cycles for the same period.
- Minimum resolvable pulse is 1 cycle of s. A 1-cycle high gives Duty=1. Pulses narrower than a Clk period on In may be lost by the synchronizer; this is acceptable.

Test Plan:
1. Assert reset for 3 cycles with In toggling -> all outputs 0 throughout; state IDLE; Level 0 on the first cycle after reset releases.
2. CNT_W=8, E=1; In repeats 3 cycles high / 5 low -> first Valid after the second synchronized rise with Duty=3, Period=8; Valid repeats every 8 cycles; Locked=1 after the first Valid; no Valid for the partial first period.
3. After lock, hold In low -> exactly one Timeout pulse 255 cycles after the last rise; Locked=0; Duty=3 and Period=8 retained; Level=0. Repeat holding In high -> Timeout with Level=1.
4. In with a 1-cycle high pulse every 4 cycles -> Duty=1, Period=4 on every Valid.
5. Drop E to 0 in mid-HIGH -> no Valid; Locked=0 next cycle; Duty/Period unchanged. Re-assert E -> first period discarded; Valid only after two further rises.
6. Period boundary: next rise arrives exactly 255 cycles after the previous one -> Valid with Period=255 and no Timeout. Period of 256 -> Timeout at cycle 255, then ARM; no Valid for that period.
